// File: rtl/prod_div_pkg.sv
// Shared types and constants for the sequential product divider.
package prod_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int OW_DEF = 16;

  localparam logic [OW_DEF-1:0] SAT_ONES = {OW_DEF{1'b1}};

endpackage

// File: rtl/prod_div_step.sv
// One restoring-division iteration: shift in a dividend bit, compare, conditionally subtract.
module prod_div_step #(
  parameter int OW = 16
) (
  input  logic [OW-1:0] rem,
  input  logic          bit_in,
  input  logic [OW-1:0] divisor,
  output logic [OW-1:0] rem_next,
  output logic          qbit
);

  logic [OW:0] wide;

  assign wide = {rem, bit_in};

  // The difference always fits in OW bits because rem < divisor on entry.
  always_comb begin
    rem_next = wide[OW-1:0];
    qbit     = 1'b0;
    if (wide >= {1'b0, divisor}) begin
      rem_next = wide[OW-1:0] - divisor;
      qbit     = 1'b1;
    end else begin
      rem_next = wide[OW-1:0];
      qbit     = 1'b0;
    end
  end

endmodule

// File: rtl/prod_div_seq.sv
// Sequential restoring divider: 2*OW-bit product / OW-bit operand, one quotient bit per clock.
// Optional PROD_DIV_EARLY_EXIT_EN finishes early once the remaining work is all zeros.
module prod_div_seq
  import prod_div_pkg::*;
#(
  parameter int OW    = OW_DEF,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*OW-1:0] p_in,
  input  logic [OW-1:0]   y_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OW-1:0]   q_out,
  output logic [OW-1:0]   r_out,
  output logic            ovf,
  output logic            dbz
);

  state_t state;
  state_t state_nxt;

  logic [OW-1:0]    rem;
  logic [OW-1:0]    shreg;
  logic [OW-1:0]    divisor;
  logic [CNT_W-1:0] cnt;
  logic [OW-1:0]    rem_next;
  logic             qbit;
  logic             early;
  logic             y_zero;
  logic             too_big;

  assign y_zero  = (y_in == {OW{1'b0}});
  assign too_big = (p_in[2*OW-1:OW] >= y_in);

  prod_div_step #(.OW(OW)) u_step (
    .rem      (rem),
    .bit_in   (shreg[OW-1]),
    .divisor  (divisor),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  // shreg holds unconsumed dividend bits on top and finished quotient bits below.
  always_comb begin
    early = 1'b0;
`ifdef PROD_DIV_EARLY_EXIT_EN
    if ((rem == {OW{1'b0}}) && ((shreg & ~({OW{1'b1}} >> cnt)) == {OW{1'b0}})) begin
      early = 1'b1;
    end else begin
      early = 1'b0;
    end
`endif
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (y_zero || too_big) begin
            state_nxt = DONE;
          end else begin
            state_nxt = BUSY;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (early || (cnt == CNT_W'(1))) begin
          state_nxt = DONE;
        end else begin
          state_nxt = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and datapath; handshake flags are registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      rem       <= {OW{1'b0}};
      shreg     <= {OW{1'b0}};
      divisor   <= {OW{1'b0}};
      cnt       <= {CNT_W{1'b0}};
      q_out     <= {OW{1'b0}};
      r_out     <= {OW{1'b0}};
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            divisor <= y_in;
            if (y_zero) begin
              q_out <= {OW{1'b1}};
              r_out <= p_in[OW-1:0];
              dbz   <= 1'b1;
              ovf   <= 1'b0;
            end else if (too_big) begin
              q_out <= {OW{1'b1}};
              r_out <= {OW{1'b0}};
              dbz   <= 1'b0;
              ovf   <= 1'b1;
            end else begin
              rem   <= p_in[2*OW-1:OW];
              shreg <= p_in[OW-1:0];
              cnt   <= CNT_W'(OW);
            end
          end
        end
        BUSY: begin
          if (early) begin
            q_out <= shreg << cnt;
            r_out <= rem;
            ovf   <= 1'b0;
            dbz   <= 1'b0;
            cnt   <= {CNT_W{1'b0}};
          end else begin
            rem   <= rem_next;
            shreg <= {shreg[OW-2:0], qbit};
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              q_out <= {shreg[OW-2:0], qbit};
              r_out <= rem_next;
              ovf   <= 1'b0;
              dbz   <= 1'b0;
            end
          end
        end
        DONE: begin
          divisor <= divisor;
        end
        default: begin
          divisor <= divisor;
        end
      endcase
    end
  end

endmodule

// File: doc/prod_div_seq.md
Name: prod_div_seq

Overview:
- Sequential restoring divider; the inverse end of the 16x16 multiplier datapath.
- Takes a 32-bit product and a 16-bit operand and recovers the other 16-bit operand (quotient) plus remainder.
- Used to close the loop on the approximate-multiplier tops: divide p_out by y to reconstruct x and measure approximation error.
- Valid/ready handshake on both sides; one quotient bit per clock.

Parameters:
- OW, 16, operand/quotient width; dividend width is 2*OW.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > OW.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  dividend/divisor valid.
- in_ready  out  1  block can accept an operation (high only in IDLE).
- p_in  in  2*OW  dividend (product).
- y_in  in  OW  divisor.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- q_out  out  OW  quotient.
- r_out  out  OW  remainder.
- ovf  out  1  quotient does not fit in OW bits; saturated.
- dbz  out  1  divide by zero.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; in_ready=1; out_valid=0; q_out=0; r_out=0; ovf=0; dbz=0; counter=0. rst mid-operation aborts the operation and discards its result; next cycle is IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid (accept), capture p_in and y_in:
  - y_in==0 -> DONE with q=all-ones, r=p_in[OW-1:0], dbz=1, ovf=0.
  - else p_in[2OW-1:OW] >= y_in -> DONE with q=all-ones, r=0, ovf=1.
  - else -> BUSY with partial remainder R = p_in[2OW-1:OW], shift reg = p_in[OW-1:0], counter=OW.
- BUSY: in_ready=0. Each cycle:
  - R' = {R, msb of shift reg} (OW+1 bits); shift reg shifts left.
  - if R' >= y, R = R' - y and shift in quotient bit 1; else R = R'[OW-1:0] and quotient bit 0.
  - counter decrements; when it reaches 0 the next state is DONE.
- BUSY lasts exactly OW cycles.
- DONE: out_valid=1; q_out, r_out, ovf, dbz stable. When out_valid && out_ready, go to IDLE and clear out_valid.
- Latency, accept edge to out_valid: 1 cycle for dbz/ovf; OW+1 cycles otherwise (17 for OW=16).
- No new operation is accepted while BUSY or DONE. in_ready and out_valid are never both high.
- Back-to-back: result accepted in cycle N -> in_ready=1 in cycle N+1.
- Outputs are registered; q_out/r_out keep their last value after handshake until the next result.
- Width rules:
  - Compare is on OW+1 bits; no overflow is possible because R < y always holds.
  - Exact: for non-ovf, non-dbz operations, q*y + r == p_in and r < y.

Optional Feature:
- Macro: PROD_DIV_EARLY_EXIT_EN.
- Defined: in BUSY, if R==0 and the remaining shift-register bits are all zero, the quotient is completed by shifting in counter zero bits in one cycle, and the next state is DONE. Latency becomes variable, between 2 and OW+1 cycles; results are identical.
- Undefined: fixed OW-cycle BUSY.

Decomposition:
- Shared package prod_div_pkg holds:
  - FSM state typedef (IDLE/BUSY/DONE, 2-bit);
  - OW_DEF=16 constant;
  - all-ones saturation constant.
- One natural sub-module: prod_div_step, a combinational single-iteration compare/subtract/shift (R, bit_in, y -> R_next, qbit). It is instanced once in the BUSY datapath.

Test Plan:
- p_in=32'h0000_0C00 (3072), y_in=16'd48 -> after 17 cycles out_valid=1, q_out=64, r_out=0, ovf=0, dbz=0.
- p_in=32'd1000003, y_in=16'd1000 -> q_out=1000, r_out=3, latency 17 cycles.
- p_in=32'h0001_0000, y_in=16'd1 -> 1 cycle later q_out=16'hFFFF, r_out=0, ovf=1.
- y_in=0, p_in=32'h1234_5678 -> q_out=16'hFFFF, r_out=16'h5678, dbz=1.
- out_ready held low 10 cycles after a result -> out_valid and outputs stable, in_ready=0. Then out_ready=1 for one cycle -> in_ready=1 the next cycle.
- rst asserted in BUSY cycle 5 -> next cycle IDLE with all outputs at reset values. A following op p_in=100, y_in=7 -> q_out=14, r_out=2. With PROD_DIV_EARLY_EXIT_EN, p_in=0, y_in=5 -> q_out=0, r_out=0 with latency ≤ 2.
